// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pkg
// Brief    : Shared types and default widths for the SRAM port arbiter.
// Revision : 1.0
// ============================================================================
package sram_arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int STARVE_CNT_W   = 4;

    // Which port owns the read data returning from the SRAM this cycle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } owner_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_starve_ctr
// Brief    : Counts consecutive denied fetch cycles; raises force_fetch at the limit.
// Revision : 1.0
// ============================================================================
module sram_arb_starve_ctr
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic i_gnt,
    output logic force_fetch
);

    localparam logic [STARVE_CNT_W-1:0] MAX_CNT = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != '1) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force_fetch = (starve_cnt == MAX_CNT);

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Shares one single-port SRAM between fetch and data ports, data
//            priority. Define SRAM_ARB_STARVE_GUARD_EN to bound fetch starvation.
// Revision : 1.0
// ============================================================================
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_req,
    input  logic [DATA_W/8-1:0] d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    if ((DATA_W % 8) != 0 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_params
        $error("sram_port_arbiter: illegal DATA_W or STARVE_MAX");
    end

    owner_state_t state;
    owner_state_t state_next;
    logic         force_fetch;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    sram_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_gnt       (i_gnt),
        .force_fetch (force_fetch)
    );
`else
    assign force_fetch = 1'b0;
`endif

    // Grants are masked by reset so nothing reaches the SRAM while it is held
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (d_req && !(force_fetch && i_req)) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = i_gnt | d_gnt;
        mem_wen   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_wen   = d_wen;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_addr  = i_addr;
        end
    end

    always_comb begin
        state_next = IDLE;
        if (i_gnt) begin
            state_next = RESP_I;
        end else if (d_gnt && (d_wen == '0)) begin
            state_next = RESP_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign i_rvalid = (state == RESP_I);
    assign d_rvalid = (state == RESP_D);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Self-checking bench with an SRAM model and a transaction-level reference.
// Revision : 1.0
// ============================================================================
module tb_sram_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int SMAX = 4;

    logic          clk;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic [BW-1:0] d_wen;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic [BW-1:0] mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] sram    [0:1023];
    logic [DW-1:0] ref_mem [0:1023];

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port SRAM, read latency one
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen == '0) begin
                mem_rdata <= sram[mem_addr[9:0]];
            end else begin
                for (int b = 0; b < BW; b++)
                    if (mem_wen[b]) sram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = '0; d_req = 0; d_wen = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_req = 1; i_addr = 32'h8; d_req = 1; d_wen = 4'hF; d_addr = 32'hC;
        #3;
        n_cmp++;
        if ({i_gnt, d_gnt, mem_en, mem_wen, i_rvalid, d_rvalid} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 0", {i_gnt, d_gnt, mem_en, mem_wen, i_rvalid, d_rvalid});
        end
        @(posedge clk); #1;
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({i_rvalid, d_rvalid, mem_en} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release: got %b required 000", {i_rvalid, d_rvalid, mem_en});
        end
        tick();
    endtask

    task automatic test_fetch_only();
        i_req = 1; i_addr = 32'h100;
        @(negedge clk);
        n_cmp++;
        if ({i_gnt, d_gnt, mem_en} !== 3'b101 || mem_addr !== 32'h100) begin
            n_err++;
            $display("FAIL fetch_grant: got gnt/en=%b addr=%h required 101 addr=100", {i_gnt, d_gnt, mem_en}, mem_addr);
        end
        tick();
        i_req = 0;
        @(negedge clk);
        n_cmp++;
        if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== 32'h2402_0005) begin
            n_err++;
            $display("FAIL fetch_resp: got iv=%b dv=%b data=%h required 1 0 24020005", i_rvalid, d_rvalid, i_rdata);
        end
        tick();
    endtask

    task automatic test_conflict();
        i_req = 1; i_addr = 32'h10; d_req = 1; d_wen = '0; d_addr = 32'h200;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, i_gnt} !== 2'b10 || mem_addr !== 32'h200) begin
            n_err++;
            $display("FAIL conflict_gnt: got d/i=%b addr=%h required 10 addr=200", {d_gnt, i_gnt}, mem_addr);
        end
        tick();
        d_req = 0;
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== ref_mem[10'h200] || i_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL conflict_dresp: got dv=%b data=%h ig=%b required 1 %h 1", d_rvalid, d_rdata, i_gnt, ref_mem[10'h200]);
        end
        tick();
        i_req = 0;
        @(negedge clk);
        n_cmp++;
        if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== ref_mem[10'h10]) begin
            n_err++;
            $display("FAIL conflict_iresp: got iv=%b dv=%b data=%h required 1 0 %h", i_rvalid, d_rvalid, i_rdata, ref_mem[10'h10]);
        end
        tick();
    endtask

    // Write then read the same word; returns checks for both phases
    task automatic test_write_read(input logic [AW-1:0] addr, input logic [BW-1:0] wen,
                                   input logic [DW-1:0] wdata, input logic [DW-1:0] expect_rd);
        d_req = 1; d_wen = wen; d_addr = addr; d_wdata = wdata;
        @(negedge clk);
        n_cmp++;
        if (d_gnt !== 1'b1 || mem_wen !== wen || mem_wdata !== wdata) begin
            n_err++;
            $display("FAIL write_issue: got gnt=%b wen=%b wdata=%h required 1 %b %h", d_gnt, mem_wen, mem_wdata, wen, wdata);
        end
        for (int b = 0; b < BW; b++) if (wen[b]) ref_mem[addr[9:0]][8*b +: 8] = wdata[8*b +: 8];
        tick();
        d_wen = '0; d_wdata = '0;
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || d_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL write_no_rvalid: got dv=%b iv=%b gnt=%b required 0 0 1", d_rvalid, i_rvalid, d_gnt);
        end
        tick();
        d_req = 0;
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== expect_rd) begin
            n_err++;
            $display("FAIL readback: got dv=%b data=%h required 1 %h", d_rvalid, d_rdata, expect_rd);
        end
        tick();
    endtask

    task automatic test_starvation();
        int fetch_grants;
        bit exp_i;
        fetch_grants = 0;
        tick();
        i_req = 1; i_addr = 32'h20; d_req = 1; d_wen = '0; d_addr = 32'h30;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp_i = GUARD && ((k % (SMAX + 1)) == SMAX);
            if (i_gnt) fetch_grants++;
            n_cmp++;
            if ({i_gnt, d_gnt} !== {exp_i, !exp_i}) begin
                n_err++;
                $display("FAIL starve_cycle%0d: got i/d=%b required %b", k, {i_gnt, d_gnt}, {exp_i, !exp_i});
            end
            tick();
        end
        n_cmp++;
        if (fetch_grants != (GUARD ? 20 / (SMAX + 1) : 0)) begin
            n_err++;
            $display("FAIL starve_total: got %0d fetch grants required %0d", fetch_grants, GUARD ? 20 / (SMAX + 1) : 0);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_outstanding();
        i_req = 1; i_addr = 32'h100;
        @(negedge clk);
        n_cmp++;
        if (i_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre_gnt: got %b required 1", i_gnt);
        end
        tick();
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({i_rvalid, d_rvalid, mem_en, i_gnt} !== 4'b0) begin
            n_err++;
            $display("FAIL rst_during: got iv/dv/en/ig=%b required 0000", {i_rvalid, d_rvalid, mem_en, i_gnt});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        i_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({i_rvalid, d_rvalid, mem_en} !== 3'b0) begin
            n_err++;
            $display("FAIL rst_after: got iv/dv/en=%b required 000", {i_rvalid, d_rvalid, mem_en});
        end
        tick();
    endtask

    task automatic test_random();
        bit            ri, rd;
        bit            eg_i, eg_d;
        bit            prv_i, prv_d;
        logic [DW-1:0] prv_data;
        int            starve;
        prv_i = 0; prv_d = 0; prv_data = '0; starve = 0;
        idle_inputs();
        tick();
        for (int c = 0; c < 400; c++) begin
            if (!i_req && $urandom_range(1, 0)) begin
                i_req = 1; i_addr = 32'($urandom_range(1023, 0));
            end
            if (!d_req && $urandom_range(2, 0) != 0) begin
                d_req   = 1;
                d_addr  = 32'($urandom_range(1023, 0));
                d_wen   = $urandom_range(1, 0) ? BW'($urandom) : '0;
                d_wdata = $urandom;
            end
            @(negedge clk);
            ri = i_req; rd = d_req;
            eg_i = ri && (!rd || (GUARD && starve == SMAX));
            eg_d = rd && !eg_i;
            n_cmp++;
            if ({i_gnt, d_gnt} !== {eg_i, eg_d}) begin
                n_err++;
                $display("FAIL rand_gnt c%0d: got i/d=%b required %b", c, {i_gnt, d_gnt}, {eg_i, eg_d});
            end
            n_cmp++;
            if ({i_rvalid, d_rvalid} !== {prv_i, prv_d} ||
                (prv_i && i_rdata !== prv_data) || (prv_d && d_rdata !== prv_data)) begin
                n_err++;
                $display("FAIL rand_resp c%0d: got iv=%b dv=%b id=%h dd=%h required %b %b %h",
                         c, i_rvalid, d_rvalid, i_rdata, d_rdata, prv_i, prv_d, prv_data);
            end
            prv_i = eg_i;
            prv_d = eg_d && (d_wen == '0);
            prv_data = '0;
            if (eg_i) prv_data = ref_mem[i_addr[9:0]];
            if (eg_d && d_wen == '0) prv_data = ref_mem[d_addr[9:0]];
            if (eg_d && d_wen != '0)
                for (int b = 0; b < BW; b++)
                    if (d_wen[b]) ref_mem[d_addr[9:0]][8*b +: 8] = d_wdata[8*b +: 8];
            starve = (ri && !eg_i) ? ((starve < 15) ? starve + 1 : 15) : 0;
            tick();
            if (eg_i) i_req = 0;
            if (eg_d) d_req = 0;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        for (int a = 0; a < 1024; a++) begin
            sram[a]    = $urandom;
            ref_mem[a] = sram[a];
        end
        sram[10'h100] = 32'h2402_0005; ref_mem[10'h100] = 32'h2402_0005;
        sram[10'h080] = 32'h1122_3344; ref_mem[10'h080] = 32'h1122_3344;

        test_reset();
        test_fetch_only();
        test_conflict();
        test_write_read(32'h40, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        test_write_read(32'h80, 4'b0010, 32'h0000_AB00, 32'h1122_AB44);
        test_starvation();
        test_reset_outstanding();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
